// File: rtl/button_debouncer_pkg.sv
// Shared types and defaults for the pushbutton debouncer.
//   btn_state_t          : per-channel debounce state (2 bits)
//   DEFAULT_STABLE_TICKS : consecutive matching samples needed to commit a change
//                          (about 10 ms at the 195 kHz sample strobe)
package debounce_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_PEND   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_PEND = 2'd3
  } btn_state_t;

  localparam int DEFAULT_STABLE_TICKS = 2048;

endpackage

// File: rtl/button_debouncer_if.sv
// Button bus between the board-level control logic and the debouncer.
//   tick_en     : sample strobe from the clock divider, one clk wide
//   btn_raw     : raw asynchronous button inputs, active high
//   btn_level   : debounced level
//   btn_press   : one-clk pulse on a committed 0->1 change
//   btn_release : one-clk pulse on a committed 1->0 change
// master = the side that supplies strobe/raw inputs; slave = the debouncer.
interface button_debouncer_if #(
  parameter int N_BTN = 5
);

  logic             tick_en;
  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;

  modport master (
    output tick_en,
    output btn_raw,
    input  btn_level,
    input  btn_press,
    input  btn_release
  );

  modport slave (
    input  tick_en,
    input  btn_raw,
    output btn_level,
    output btn_press,
    output btn_release
  );

endinterface

// File: rtl/button_debouncer_channel.sv
// One debounce channel: 2-flop synchronizer, state machine, stability
// counter and registered press/release pulses.
//   clk, rst_n  : master clock, asynchronous active-low reset
//   tick_en     : sample enable; state and counter only move when high
//   btn_raw     : raw button input
//   btn_level   : debounced level
//   btn_press   : one-clk pulse when a press commits
//   btn_release : one-clk pulse when a release commits
//
// state        | meaning
// -------------+------------------------------------------------------
// RELEASED     | level 0, sample agrees
// PRESS_PEND   | level 0, counting consecutive 1 samples
// PRESSED      | level 1, sample agrees
// RELEASE_PEND | level 1, counting consecutive 0 samples
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int  STABLE_TICKS = DEFAULT_STABLE_TICKS,
  localparam int CNT_W        = $clog2(STABLE_TICKS)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick_en,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic syncMeta;
  logic sample;

  btn_state_t       state, stateNext;
  logic [CNT_W-1:0] cnt, cntNext;
  logic             levelNext, pressNext, releaseNext;
  logic             cntLast;

  // Synchronizer runs every clk; only the FSM is gated by the strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      syncMeta <= 1'b0;
      sample   <= 1'b0;
    end else begin
      syncMeta <= btn_raw;
      sample   <= syncMeta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RELEASED;
      cnt         <= '0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
    end else begin
      state       <= stateNext;
      cnt         <= cntNext;
      btn_level   <= levelNext;
      btn_press   <= pressNext;
      btn_release <= releaseNext;
    end
  end

  assign cntLast = (cnt == CNT_LAST);

  // Pulses default to 0 every clk so they last exactly one cycle even when
  // tick_en is held high.
  always_comb begin
    stateNext   = state;
    cntNext     = cnt;
    levelNext   = btn_level;
    pressNext   = 1'b0;
    releaseNext = 1'b0;
    if (tick_en) begin
      case (state)
        RELEASED: begin
          if (sample) begin
            stateNext = PRESS_PEND;
            cntNext   = CNT_ONE;
          end
        end
        PRESS_PEND: begin
          if (!sample) begin
            stateNext = RELEASED;
            cntNext   = '0;
          end else if (cntLast) begin
            stateNext = PRESSED;
            cntNext   = '0;
            levelNext = 1'b1;
            pressNext = 1'b1;
          end else begin
            cntNext = cnt + CNT_ONE;
          end
        end
        PRESSED: begin
          if (!sample) begin
            stateNext = RELEASE_PEND;
            cntNext   = CNT_ONE;
          end
        end
        RELEASE_PEND: begin
          if (sample) begin
            stateNext = PRESSED;
            cntNext   = '0;
          end else if (cntLast) begin
            stateNext   = RELEASED;
            cntNext     = '0;
            levelNext   = 1'b0;
            releaseNext = 1'b1;
          end else begin
            cntNext = cnt + CNT_ONE;
          end
        end
        default: begin
          stateNext = RELEASED;
          cntNext   = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/button_debouncer.sv
// Debounces N_BTN raw pushbuttons using the clock divider's sample strobe.
//   clk, rst_n : 100 MHz master clock, asynchronous active-low reset
//   bus        : button_debouncer_if slave (tick_en, btn_raw in;
//                btn_level, btn_press, btn_release out)
// Each button is an independent debounce_channel; this level only checks
// the parameters and fans the bus out.
module button_debouncer
  import debounce_pkg::*;
#(
  parameter int  N_BTN        = 5,
  parameter int  STABLE_TICKS = DEFAULT_STABLE_TICKS,
  localparam int CNT_W        = $clog2(STABLE_TICKS)
) (
  input  logic                clk,
  input  logic                rst_n,
  button_debouncer_if.slave   bus
);

  // A one-sample window would commit on the first sample and never filter.
  generate
    if (STABLE_TICKS < 2) begin : gBadStableTicks
      $error("button_debouncer: STABLE_TICKS must be >= 2 (got %0d)", STABLE_TICKS);
    end
    if (CNT_W < 1) begin : gBadCntW
      $error("button_debouncer: counter width must be >= 1");
    end
  endgenerate

  for (genvar i = 0; i < N_BTN; i++) begin : gChannel
    debounce_channel #(
      .STABLE_TICKS (STABLE_TICKS)
    ) uChannel (
      .clk         (clk),
      .rst_n       (rst_n),
      .tick_en     (bus.tick_en),
      .btn_raw     (bus.btn_raw[i]),
      .btn_level   (bus.btn_level[i]),
      .btn_press   (bus.btn_press[i]),
      .btn_release (bus.btn_release[i])
    );
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer with STABLE_TICKS=4 and N_BTN=5.
// Reference model: raw inputs reach the sampler two clk edges later; on each
// strobe the sample is appended to a per-button history and the level flips
// once the newest STABLE_TICKS samples all disagree with the current level.
module tb_button_debouncer;

  localparam int N  = 5;
  localparam int ST = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  button_debouncer_if #(.N_BTN(N)) bus ();

  button_debouncer #(
    .N_BTN        (N),
    .STABLE_TICKS (ST)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int testCnt = 0;
  int failCnt = 0;
  int cycleNum = 0;

  // model state
  logic [N-1:0] dly1, dly2;
  logic [N-1:0] mLevel, mPress, mRelease;
  int unsigned  hist [N];

  // observed pulse bookkeeping
  int pressCnt [N];
  int relCnt [N];
  int pressCyc [N];
  int relCyc [N];

  task automatic checkResult(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCnt++;
    if (obs !== exp) begin
      failCnt++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cycleNum);
    end
  endtask

  task automatic modelReset();
    dly1 = '0;
    dly2 = '0;
    mLevel = '0;
    mPress = '0;
    mRelease = '0;
    for (int i = 0; i < N; i++) hist[i] = 0;
  endtask

  task automatic modelEdge(input logic [N-1:0] raw, input logic tick);
    int unsigned mask;
    mask = (1 << ST) - 1;
    mPress = '0;
    mRelease = '0;
    if (tick) begin
      for (int i = 0; i < N; i++) begin
        hist[i] = ((hist[i] << 1) | 32'(dly2[i])) & 32'hFFFF;
        if (!mLevel[i] && ((hist[i] & mask) == mask)) begin
          mLevel[i] = 1'b1;
          mPress[i] = 1'b1;
        end else if (mLevel[i] && ((hist[i] & mask) == 0)) begin
          mLevel[i] = 1'b0;
          mRelease[i] = 1'b1;
        end
      end
    end
    dly2 = dly1;
    dly1 = raw;
  endtask

  task automatic clearCounts();
    for (int i = 0; i < N; i++) begin
      pressCnt[i] = 0;
      relCnt[i] = 0;
      pressCyc[i] = -1;
      relCyc[i] = -1;
    end
  endtask

  // One clk: drive, wait for the edge, advance the model, compare.
  task automatic cycle(input logic [N-1:0] raw, input logic tick);
    bus.btn_raw = raw;
    bus.tick_en = tick;
    @(posedge clk);
    #1;
    cycleNum++;
    if (!rst_n) modelReset();
    else modelEdge(raw, tick);
    checkResult("level", 32'(bus.btn_level), 32'(mLevel));
    checkResult("press", 32'(bus.btn_press), 32'(mPress));
    checkResult("release", 32'(bus.btn_release), 32'(mRelease));
    checkResult("press_and_release", 32'(bus.btn_press & bus.btn_release), 32'd0);
    for (int i = 0; i < N; i++) begin
      if (bus.btn_press[i]) begin
        pressCnt[i]++;
        if (pressCyc[i] < 0) pressCyc[i] = cycleNum;
      end
      if (bus.btn_release[i]) begin
        relCnt[i]++;
        if (relCyc[i] < 0) relCyc[i] = cycleNum;
      end
    end
  endtask

  // n strobe periods of 4 clk, strobe on the last clk of each period
  task automatic runTicks(input logic [N-1:0] raw, input int n);
    for (int t = 0; t < n; t++) begin
      cycle(raw, 1'b0);
      cycle(raw, 1'b0);
      cycle(raw, 1'b0);
      cycle(raw, 1'b1);
    end
  endtask

  logic [N-1:0] rawVec;
  int startCyc;

  initial begin
    modelReset();
    clearCounts();
    bus.btn_raw = '1;
    bus.tick_en = 1'b0;
    rst_n = 1'b0;

    // reset with all buttons held
    #2;
    checkResult("reset_level", 32'(bus.btn_level), 32'd0);
    checkResult("reset_press", 32'(bus.btn_press), 32'd0);
    runTicks('1, 2);
    rst_n = 1'b1;
    clearCounts();
    runTicks('1, 6);
    checkResult("held_after_reset_level", 32'(bus.btn_level), 32'h1F);
    for (int i = 0; i < N; i++) begin
      checkResult("held_after_reset_press_cnt", 32'(pressCnt[i]), 32'd1);
      checkResult("held_after_reset_rel_cnt", 32'(relCnt[i]), 32'd0);
    end

    // release everything, then clean press on bit 0
    runTicks('0, 6);
    clearCounts();
    runTicks(5'b00001, 6);
    checkResult("clean_press_cnt0", 32'(pressCnt[0]), 32'd1);
    checkResult("clean_press_others", 32'(pressCnt[1] + pressCnt[2] + pressCnt[3] + pressCnt[4]), 32'd0);

    // bounce on bit 2: 1,0,1,1,0 then held 1
    clearCounts();
    runTicks(5'b00101, 1);
    runTicks(5'b00001, 1);
    runTicks(5'b00101, 2);
    runTicks(5'b00001, 1);
    checkResult("bounce_no_pulse", 32'(pressCnt[2] + relCnt[2]), 32'd0);
    runTicks(5'b00101, 6);
    checkResult("bounce_press_cnt", 32'(pressCnt[2]), 32'd1);

    // release glitch on bit 1
    runTicks(5'b00111, 6);
    clearCounts();
    runTicks(5'b00101, 2);
    runTicks(5'b00111, 3);
    checkResult("glitch_level1", 32'(bus.btn_level[1]), 32'd1);
    checkResult("glitch_no_release", 32'(relCnt[1]), 32'd0);
    runTicks(5'b00101, 6);
    checkResult("glitch_then_release", 32'(relCnt[1]), 32'd1);

    // simultaneous: bit 3 released, bit 4 pressed on the same tick
    runTicks(5'b01000, 6);
    clearCounts();
    runTicks(5'b10000, 6);
    checkResult("simul_rel3_cnt", 32'(relCnt[3]), 32'd1);
    checkResult("simul_press4_cnt", 32'(pressCnt[4]), 32'd1);
    checkResult("simul_same_cycle", 32'(relCyc[3]), 32'(pressCyc[4]));

    // mid-operation reset with bit 0 in PRESS_PEND, cnt=2
    clearCounts();
    runTicks(5'b10001, 2);
    checkResult("pend_level_before_rst", 32'(bus.btn_level), 32'h10);
    rst_n = 1'b0;
    #2;
    checkResult("midrst_level", 32'(bus.btn_level), 32'd0);
    checkResult("midrst_press", 32'(bus.btn_press), 32'd0);
    checkResult("midrst_release", 32'(bus.btn_release), 32'd0);
    modelReset();
    runTicks(5'b10001, 1);
    rst_n = 1'b1;
    checkResult("midrst_no_pulse", 32'(pressCnt[0] + relCnt[4]), 32'd0);
    runTicks(5'b10001, 6);
    checkResult("after_midrst_level", 32'(bus.btn_level), 32'h11);

    // randomized: random strobe spacing, occasional changes and glitches
    rawVec = '0;
    for (int t = 0; t < 500; t++) begin
      logic [N-1:0] drive;
      int gap;
      if ($urandom_range(0, 5) == 0) rawVec[$urandom_range(0, N - 1)] ^= 1'b1;
      drive = rawVec;
      if ($urandom_range(0, 9) == 0) drive[$urandom_range(0, N - 1)] ^= 1'b1;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) cycle(drive, 1'b0);
      cycle(drive, 1'b1);
    end

    // stress: tick_en tied high
    for (int c = 0; c < 12; c++) cycle('0, 1'b1);
    clearCounts();
    startCyc = cycleNum;
    for (int c = 0; c < 16; c++) cycle(5'b00001, 1'b1);
    checkResult("stress_press_cnt", 32'(pressCnt[0]), 32'd1);
    checkResult("stress_commit_clk", 32'(pressCyc[0] - startCyc), 32'd6);
    checkResult("stress_level", 32'(bus.btn_level), 32'h01);

    $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
    $finish;
  end

endmodule
